// File: rtl/core_local_interruptor.sv
// -----------------------------------------------------------------------------
// core_local_interruptor
//
// Machine-level core-local interruptor: a free-running 64-bit mtime counter,
// a 64-bit mtimecmp compare register and a single msip software-interrupt bit.
// These are reached through a simple request/complete register port.
//
// Handshake: the requester raises clint_valid with addr/wdata/wstrb and holds
// them until clint_ready. When the block is IDLE, a request is taken on the
// next rising edge. Any write happens on that edge, and read data is captured
// from the pre-edge register values. clint_ready is then high for exactly one
// cycle (state RESP), and clint_rdata carries the read value only during that
// cycle. clint_valid seen while in RESP is ignored, so at most one access is
// taken every two cycles.
//
// Register map (offset = clint_addr[15:0]):
//   0x0000 msip (bit 0)   0x4000/0x4004 mtimecmp lo/hi
//   0xBFF8/0xBFFC mtime lo/hi
// Unmapped and unaligned offsets read 0, ignore writes and still complete.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   clint_valid        request present
//   clint_addr[31:0]   byte address (bits [15:0] decoded)
//   clint_wdata[31:0]  write data
//   clint_wstrb[3:0]   byte enables, 4'b0000 = read
//   clint_rdata[31:0]  read data (0 unless clint_ready)
//   clint_ready        one-cycle completion pulse
//   timer_irpt         registered (mtime >= mtimecmp)
//   soft_irpt          registered copy of msip
//
// Configuration macro CLINT_PRESCALE_EN: when it is defined, mtime advances
// once every CLINT_TIMER_DIV clocks. When it is undefined, mtime advances on
// every clock and CLINT_TIMER_DIV has no effect.
// -----------------------------------------------------------------------------
module core_local_interruptor #(
  parameter int unsigned CLINT_TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clint_valid,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        timer_irpt,
  output logic        soft_irpt
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTCMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTCMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        msip_q;
  logic [31:0] rdata_q;
  logic        timer_q;
  logic        soft_q;
  logic        tick;
  logic        accept;
  logic        acc_wr;
  logic [15:0] offset;
  logic [31:0] rd_val;

  // Byte-lane merge of write data into an existing 32-bit register half.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Timebase tick
  // ---------------------------------------------------------------------------
`ifdef CLINT_PRESCALE_EN
  localparam logic [15:0] DIV_M1 = 16'(CLINT_TIMER_DIV - 1);
  logic [15:0] presc_q;

  // The tick fires on the edge where the counter wraps back to 0, so the first
  // tick after reset lands on the CLINT_TIMER_DIV-th edge.
  assign tick = (presc_q == DIV_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 16'd0;
    end else if (tick) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^clint_addr[31:16];
`else
  assign tick = 1'b1;

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{clint_addr[31:16], (CLINT_TIMER_DIV == 32'd0)};
`endif

  // ---------------------------------------------------------------------------
  // Access FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clint_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept      = (state_q == IDLE) && clint_valid;
    clint_ready = (state_q == RESP);
    clint_rdata = (state_q == RESP) ? rdata_q : 32'd0;
  end

  assign acc_wr     = accept && (clint_wstrb != 4'b0000);
  assign offset     = clint_addr[15:0];
  assign timer_irpt = timer_q;
  assign soft_irpt  = soft_q;

  // Read mux over current (pre-edge) register values. The mapped offsets are
  // all word aligned, so an unaligned offset never matches and reads 0.
  always_comb begin
    rd_val = 32'd0;
    case (offset)
      OFF_MSIP:     rd_val = {31'd0, msip_q};
      OFF_MTCMP_LO: rd_val = mtimecmp_q[31:0];
      OFF_MTCMP_HI: rd_val = mtimecmp_q[63:32];
      OFF_MTIME_LO: rd_val = mtime_q[31:0];
      OFF_MTIME_HI: rd_val = mtime_q[63:32];
      default:      rd_val = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file, timer and interrupt outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      rdata_q    <= 32'd0;
      timer_q    <= 1'b0;
      soft_q     <= 1'b0;
    end else begin
      rdata_q <= accept ? rd_val : 32'd0;
      timer_q <= (mtime_q >= mtimecmp_q);
      soft_q  <= msip_q;

      if (acc_wr && (offset == OFF_MSIP) && clint_wstrb[0]) begin
        msip_q <= clint_wdata[0];
      end

      // A partial mtimecmp write takes effect at once; software is expected
      // to write the high half first so no spurious match occurs.
      if (acc_wr && (offset == OFF_MTCMP_LO)) begin
        mtimecmp_q[31:0] <= merge_bytes(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
      end
      if (acc_wr && (offset == OFF_MTCMP_HI)) begin
        mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
      end

      // A software write to either mtime half wins over the tick. The tick on
      // that edge is dropped entirely, so the other half carries nothing.
      if (acc_wr && (offset == OFF_MTIME_LO)) begin
        mtime_q[31:0] <= merge_bytes(mtime_q[31:0], clint_wdata, clint_wstrb);
      end else if (acc_wr && (offset == OFF_MTIME_HI)) begin
        mtime_q[63:32] <= merge_bytes(mtime_q[63:32], clint_wdata, clint_wstrb);
      end else if (tick) begin
        mtime_q <= mtime_q + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_local_interruptor.sv
module tb_core_local_interruptor;

`ifdef CLINT_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        clint_valid;
  logic [31:0] clint_addr;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;
  logic [31:0] clint_rdata;
  logic        clint_ready;
  logic        timer_irpt;
  logic        soft_irpt;

  always #5 clk = ~clk;

  core_local_interruptor #(.CLINT_TIMER_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .clint_valid (clint_valid),
    .clint_addr  (clint_addr),
    .clint_wdata (clint_wdata),
    .clint_wstrb (clint_wstrb),
    .clint_rdata (clint_rdata),
    .clint_ready (clint_ready),
    .timer_irpt  (timer_irpt),
    .soft_irpt   (soft_irpt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: the architectural state as plain variables.
  // m_busy is 1 in the cycle after a request was taken (response showing).
  // ---------------------------------------------------------------------------
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_soft;
  logic        m_timer;
  logic        m_busy;
  logic [31:0] m_rdata;
  int          m_cycles_since_tick;

  function automatic logic [31:0] m_read(input logic [15:0] off);
    case (off)
      16'h0000: return {31'd0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
      16'hBFFC: return m_mtime[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old_val,
                                          input logic [31:0] wd,
                                          input logic [3:0]  ws);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Advance the model across one rising edge given the inputs at that edge.
  task automatic model_edge(input logic r, input logic v, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
    logic [63:0] n_mtime;
    logic        n_timer, n_soft, acc, tk;
    logic [31:0] n_rdata;
    logic [15:0] off;
    if (r) begin
      m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_soft = 1'b0;
      m_timer = 1'b0; m_busy = 1'b0; m_rdata = 32'd0; m_cycles_since_tick = 0;
      return;
    end
    off = a[15:0];
    acc = v && !m_busy;
    // mtime advances once every DIV edges counted from reset release.
    m_cycles_since_tick++;
    tk = (m_cycles_since_tick == DIV);
    if (tk) m_cycles_since_tick = 0;
    n_mtime = m_mtime + (tk ? 64'd1 : 64'd0);
    n_timer = (m_mtime >= m_cmp);
    n_soft  = m_msip;
    n_rdata = acc ? m_read(off) : 32'd0;
    if (acc && ws != 4'b0000) begin
      case (off)
        16'h0000: if (ws[0]) m_msip = wd[0];
        16'h4000: m_cmp[31:0]  = m_merge(m_cmp[31:0], wd, ws);
        16'h4004: m_cmp[63:32] = m_merge(m_cmp[63:32], wd, ws);
        16'hBFF8: n_mtime = {m_mtime[63:32], m_merge(m_mtime[31:0], wd, ws)};
        16'hBFFC: n_mtime = {m_merge(m_mtime[63:32], wd, ws), m_mtime[31:0]};
        default: ;
      endcase
    end
    m_mtime = n_mtime;
    m_timer = n_timer;
    m_soft  = n_soft;
    m_rdata = n_rdata;
    m_busy  = acc;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard check
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic r, input logic v, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] ws);
    rst = r; clint_valid = v; clint_addr = a; clint_wdata = wd; clint_wstrb = ws;
    @(posedge clk);
    model_edge(r, v, a, wd, ws);
    #1;
    chk("ready", 64'(clint_ready), 64'(m_busy));
    chk("rdata", 64'(clint_rdata), 64'(m_rdata));
    chk("timer_irpt", 64'(timer_irpt), 64'(m_timer));
    chk("soft_irpt", 64'(soft_irpt), 64'(m_soft));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd);
    cyc(1'b0, 1'b1, a, wd, ws);
    rd = clint_rdata;
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] rd;
  logic [15:0] offs [8] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
                            16'hBFFC, 16'h1234, 16'h4001, 16'hBFFA};

  initial begin
    rst = 1'b1; clint_valid = 1'b0; clint_addr = '0; clint_wdata = '0; clint_wstrb = '0;
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset values of mtimecmp and the interrupt lines.
    access(32'h0000_4004, 32'd0, 4'b0000, rd);
    chk("rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
    chk("rst_timer", 64'(timer_irpt), 64'd0);
    access(32'h0000_4000, 32'd0, 4'b0000, rd);
    chk("rst_cmp_lo", 64'(rd), 64'hFFFF_FFFF);

    // Timer compare: high half then low half, restart mtime at 0.
    access(32'h0000_4004, 32'd0, 4'hF, rd);
    access(32'h0000_4000, 32'd20, 4'hF, rd);
    access(32'h0000_BFFC, 32'd0, 4'hF, rd);
    access(32'h0000_BFF8, 32'd0, 4'hF, rd);
    for (int i = 0; i < 60 && !timer_irpt; i++) idle(1);
    chk("timer_rise", 64'(timer_irpt), 64'd1);
    access(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, rd);
    chk("timer_drop", 64'(timer_irpt), 64'd0);

    // Software interrupt set / read-only access / cleared.
    access(32'h0000_0000, 32'd1, 4'b0001, rd);
    chk("msip_set", 64'(soft_irpt), 64'd1);
    access(32'h0000_0000, 32'd0, 4'b0000, rd);
    chk("msip_read", 64'(rd), 64'd1);
    chk("msip_hold", 64'(soft_irpt), 64'd1);
    access(32'h0000_0000, 32'd0, 4'b1110, rd);
    chk("msip_strb", 64'(soft_irpt), 64'd1);
    access(32'h0000_0000, 32'd0, 4'b0001, rd);
    chk("msip_clr", 64'(soft_irpt), 64'd0);

    // mtime full wrap.
    access(32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF, rd);
    access(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, rd);
    access(32'h0000_BFF8, 32'd0, 4'b0000, rd);
    chk("wrap_lo", 64'(rd), 64'd0);
    access(32'h0000_BFFC, 32'd0, 4'b0000, rd);
    chk("wrap_hi", 64'(rd), 64'd0);

    // Carry from the low half into the high half.
    access(32'h0000_BFFC, 32'd0, 4'hF, rd);
    access(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, rd);
    access(32'h0000_BFFC, 32'd0, 4'b0000, rd);
    chk("carry_hi", 64'(rd), (DIV == 1) ? 64'd1 : 64'(m_read(16'hBFFC)));

    // Byte strobes and an unaligned write that must be ignored.
    access(32'h0000_4000, 32'hAABB_CCDD, 4'b0101, rd);
    access(32'h0000_4000, 32'd0, 4'b0000, rd);
    chk("cmp_bytes", 64'(rd), 64'hFFBB_FFDD);
    access(32'h0000_4001, 32'd0, 4'hF, rd);
    chk("unaligned_rd", 64'(rd), 64'd0);
    access(32'h0000_4000, 32'd0, 4'b0000, rd);
    chk("unaligned_wr", 64'(rd), 64'hFFBB_FFDD);

    // Valid held through RESP is ignored, then taken again.
    cyc(1'b0, 1'b1, 32'h0000_4004, 32'd0, 4'd0);
    cyc(1'b0, 1'b1, 32'h0000_4004, 32'd0, 4'd0);
    chk("resp_ignored", 64'(clint_ready), 64'd0);
    cyc(1'b0, 1'b1, 32'h0000_4004, 32'd0, 4'd0);
    chk("reaccept", 64'(clint_ready), 64'd1);
    idle(1);

    // Reset during RESP with valid held aborts the access.
    cyc(1'b0, 1'b1, 32'h0000_4000, 32'd0, 4'd0);
    cyc(1'b1, 1'b1, 32'h0000_4000, 32'd0, 4'd0);
    chk("abort_ready", 64'(clint_ready), 64'd0);
    idle(2);
    chk("abort_noready", 64'(clint_ready), 64'd0);
    access(32'h0000_4000, 32'd0, 4'b0000, rd);
    chk("abort_cmp", 64'(rd), 64'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 32'h0000_1234, 32'd0, 4'd0);
    chk("unmapped_ready", 64'(clint_ready), 64'd1);
    chk("unmapped_rdata", 64'(clint_rdata), 64'd0);
    idle(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] off;
      logic [31:0] wd;
      logic [3:0]  ws;
      off = offs[$urandom_range(0, 7)];
      wd  = $urandom;
      if (off == 16'h4004 || off == 16'hBFFC) wd = 32'($urandom_range(0, 1));
      if (off == 16'h4000 && $urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 300));
      ws  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          {16'($urandom), off}, wd, ws);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_local_interruptor.md
CORE_LOCAL_INTERRUPTOR -- requirements
Module: core_local_interruptor

Interface
REQ-001 SHALL have parameter CLINT_TIMER_DIV, default 1, mtime prescale divisor in clk cycles (legal 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port clint_valid  input  1  request present; held by requester until clint_ready.
REQ-005 SHALL have port clint_addr  input  32  byte address; only bits [15:0] decoded (upstream selects the region).
REQ-006 SHALL have port clint_wdata  input  32  write data.
REQ-007 SHALL have port clint_wstrb  input  4  byte enables; 4'b0000 = read.
REQ-008 SHALL have port clint_rdata  output  32  read data, valid while clint_ready=1, else 0.
REQ-009 SHALL have port clint_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port timer_irpt  output  1  machine timer interrupt level to the CSR unit.
REQ-011 SHALL have port soft_irpt  output  1  machine software interrupt level to the CSR unit.

Function
REQ-012 Register map (offset = clint_addr[15:0]): 0x0000 msip (bit0 only, others read 0); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-013 Unmapped or unaligned (addr[1:0]!=0) offsets SHALL read 0, ignore writes, and still complete with clint_ready.
REQ-014 FSM states IDLE and RESP; IDLE + clint_valid=1 -> access performed that edge, go RESP; RESP -> IDLE unconditionally.
REQ-015 clint_ready SHALL be 1 exactly in RESP; latency request-to-ready = 1 cycle; clint_valid in RESP SHALL be ignored (max one access per 2 cycles).
REQ-016 Writes SHALL update only bytes whose wstrb bit is 1; msip uses wstrb[0] and wdata[0].
REQ-017 Read data SHALL be registered from register values before any same-edge update.
REQ-018 mtime (64 bit) SHALL increment by 1 on each tick, wrapping 2^64-1 -> 0 with no flag.
REQ-019 Software write to either mtime half SHALL take priority over the tick on that edge; the other half is unaffected, with no carry applied from the discarded tick.
REQ-020 timer_irpt SHALL be registered: value after edge n = (mtime >= mtimecmp, unsigned 64-bit, using pre-edge values).
REQ-021 soft_irpt SHALL equal registered msip bit (set/cleared one edge after the write edge).
REQ-022 Writing only one mtimecmp half SHALL compare against the partial value immediately (software sequences high-then-low).

Reset
REQ-023 While rst=1 at an edge: FSM=IDLE, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescale counter=0, clint_ready=0, clint_rdata=0, timer_irpt=0, soft_irpt=0.
REQ-024 Reset asserted mid-access (RESP) SHALL abort it; no ready pulse follows after reset release until a new request.
REQ-025 First tick after reset release SHALL occur on the first edge with rst=0 (prescale disabled) or the CLINT_TIMER_DIV-th edge (prescale enabled).

Configuration
REQ-026 Macro CLINT_PRESCALE_EN defined: a 16-bit counter counts 0..CLINT_TIMER_DIV-1, tick asserted on the edge it wraps to 0; mtime advances once per CLINT_TIMER_DIV cycles; CLINT_TIMER_DIV=1 gives a tick every cycle.
REQ-027 Macro CLINT_PRESCALE_EN undefined: no prescale counter, tick every cycle, CLINT_TIMER_DIV ignored.

Verification
REQ-028 Reset then read 0x4004 -> clint_ready high 1 cycle later, clint_rdata=32'hFFFF_FFFF; timer_irpt=0.
REQ-029 Write mtimecmp hi=0 then lo=20 (no prescale), mtime=0 -> timer_irpt rises the edge after mtime first reads 20; write lo=0xFFFF_FFFF -> timer_irpt drops next edge.
REQ-030 Write 0x0000 wdata=1 wstrb=4'b0001 -> soft_irpt=1 next edge; same with wstrb=4'b0000 -> read, soft_irpt unchanged.
REQ-031 Write mtime lo=32'hFFFF_FFFF, hi=0 -> after one tick mtime reads hi=1, lo=0; write hi=lo=FFFF_FFFF -> wraps to 0.
REQ-032 CLINT_PRESCALE_EN, CLINT_TIMER_DIV=4 -> mtime reads 0 for edges 1-3 after reset release, 1 after edge 4, 25 after 100 cycles.
REQ-033 Assert rst during RESP with clint_valid held -> clint_ready=0, all registers at reset values; unmapped read 0x1234 -> rdata=0, ready pulses.
